// File: rtl/sdr_init_seq_pkg.sv
// rtl/sdr_init_seq_pkg.sv - shared states, SDRAM command codes and mode-word helpers
// Purpose: state encoding and constants shared by the SDRAM init sequencer files.
// Ports: none (package).
package sdr_init_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PWR  = 3'd1,
        ST_PRE  = 3'd2,
        ST_AREF = 3'd3,
        ST_LMR  = 3'd4,
        ST_DONE = 3'd5
    } state_t;

    // {nRAS, nCAS, nWE}; nCS is held low, so NOP is the idle command.
    localparam logic [2:0] CMD_NOP  = 3'b111;
    localparam logic [2:0] CMD_PRE  = 3'b010;
    localparam logic [2:0] CMD_AREF = 3'b001;
    localparam logic [2:0] CMD_LMR  = 3'b000;

    // Mode word layout: A9 write-burst, A8:7 op mode (0), A6:4 CAS latency,
    // A3 burst type, A2:0 burst length code.
    function automatic logic [12:0] mr_word(input logic       wb,
                                            input logic [2:0] cl,
                                            input logic       bt,
                                            input logic [2:0] bl);
        return {3'b000, wb, 2'b00, cl, bt, bl};
    endfunction

    localparam logic [12:0] MR_WORD_DFLT = mr_word(1'b0, 3'd3, 1'b0, 3'd2);

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sdr_wait_cnt.sv
// rtl/sdr_wait_cnt.sv - load/expire down-counter for state dwell times
// Purpose: loaded with (cycles-1) on state entry, o_expired high when it reaches zero.
// Ports: i_clk, i_rst_n (sync active-low), i_load, i_load_val[W], o_expired.
module sdr_wait_cnt #(
    parameter int             W       = 4,
    parameter logic [W-1:0]   RST_VAL = '0
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    output logic         o_expired
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_cnt <= RST_VAL;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_expired = (r_cnt == '0);

endmodule

// File: rtl/sdr_init_seq.sv
// rtl/sdr_init_seq.sv - SDRAM power-up / re-initialisation sequencer
// Purpose: power-up wait with CKE, PRECHARGE ALL, N x AUTO REFRESH, LOAD MODE REGISTER,
//          then init_done; re-runs from PRECHARGE on request with an optional mode override.
// Ports: clk, rst_n (sync active-low); reinit_req/mr_ovr_en/mr_cfg in; reinit_ack,
//        init_busy, init_done out; registered SDRAM pins sdr_CKE, sdr_nCS/nRAS/nCAS/nWE,
//        sdr_BA, sdr_A, sdr_DQM.
module sdr_init_seq
    import sdr_init_seq_pkg::*;
#(
    parameter int               ROW_W      = 13,
    parameter int               BA_W       = 2,
    parameter int               DQM_W      = 2,
    parameter int               T_PWR_CYC  = 16700,
    parameter int               T_RP_CYC   = 3,
    parameter int               T_RFC_CYC  = 10,
    parameter int               T_MRD_CYC  = 2,
    parameter int               N_AREF     = 2,
    parameter logic [ROW_W-1:0] MR_DEFAULT = ROW_W'(MR_WORD_DFLT)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              reinit_req,
    input  logic              mr_ovr_en,
    input  logic [ROW_W-1:0]  mr_cfg,
    output logic              reinit_ack,
    output logic              init_busy,
    output logic              init_done,
    output logic              sdr_CKE,
    output logic              sdr_nCS,
    output logic              sdr_nRAS,
    output logic              sdr_nCAS,
    output logic              sdr_nWE,
    output logic [BA_W-1:0]   sdr_BA,
    output logic [ROW_W-1:0]  sdr_A,
    output logic [DQM_W-1:0]  sdr_DQM
);

    localparam int T_MAX = max_int(max_int(T_PWR_CYC, T_RP_CYC), max_int(T_RFC_CYC, T_MRD_CYC));
    localparam int CNT_W = $clog2(T_MAX) + 1;
    localparam logic [ROW_W-1:0] A_ALL_BANKS = ROW_W'(1) << 10;

    state_t             r_state;
    state_t             w_state_nxt;
    logic               w_enter;
    logic               w_accept;
    logic               w_aref_clr;
    logic               w_aref_inc;
    logic               w_cnt_exp;
    logic [CNT_W-1:0]   w_load_val;
    logic [2:0]         w_cmd;
    logic [ROW_W-1:0]   w_a;

    logic [3:0]         r_aref_cnt;
    logic [ROW_W-1:0]   r_mode;
    logic               r_cke;
    logic [2:0]         r_cmd;
    logic [ROW_W-1:0]   r_a;
    logic [DQM_W-1:0]   r_dqm;
    logic               r_busy;
    logic               r_done;
    logic               r_ack;

    // Reset value 1 keeps IDLE for one full cycle after reset is released.
    sdr_wait_cnt #(
        .W       (CNT_W),
        .RST_VAL (CNT_W'(1))
    ) u_wait_cnt (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_load     (w_enter),
        .i_load_val (w_load_val),
        .o_expired  (w_cnt_exp)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // w_enter marks every state entry, including AREF re-entering itself, so
    // each entry reloads the dwell counter and issues exactly one command.
    always_comb begin
        w_state_nxt = r_state;
        w_enter     = 1'b0;
        w_accept    = 1'b0;
        w_aref_clr  = 1'b0;
        w_aref_inc  = 1'b0;
        w_load_val  = '0;
        case (r_state)
            ST_IDLE: begin
                if (w_cnt_exp) begin
                    w_state_nxt = ST_PWR;
                    w_enter     = 1'b1;
                    w_load_val  = CNT_W'(T_PWR_CYC - 1);
                end
            end
            ST_PWR: begin
                if (w_cnt_exp) begin
                    w_state_nxt = ST_PRE;
                    w_enter     = 1'b1;
                    w_aref_clr  = 1'b1;
                    w_load_val  = CNT_W'(T_RP_CYC - 1);
                end
            end
            ST_PRE: begin
                if (w_cnt_exp) begin
                    w_state_nxt = ST_AREF;
                    w_enter     = 1'b1;
                    w_load_val  = CNT_W'(T_RFC_CYC - 1);
                end
            end
            ST_AREF: begin
                if (w_cnt_exp) begin
                    w_enter    = 1'b1;
                    w_aref_inc = 1'b1;
                    if (r_aref_cnt == 4'(N_AREF - 1)) begin
                        w_state_nxt = ST_LMR;
                        w_load_val  = CNT_W'(T_MRD_CYC - 1);
                    end else begin
                        w_state_nxt = ST_AREF;
                        w_load_val  = CNT_W'(T_RFC_CYC - 1);
                    end
                end
            end
            ST_LMR: begin
                if (w_cnt_exp) begin
                    w_state_nxt = ST_DONE;
                    w_enter     = 1'b1;
                end
            end
            ST_DONE: begin
                if (reinit_req) begin
                    w_state_nxt = ST_PRE;
                    w_enter     = 1'b1;
                    w_accept    = 1'b1;
                    w_aref_clr  = 1'b1;
                    w_load_val  = CNT_W'(T_RP_CYC - 1);
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_enter     = 1'b1;
            end
        endcase
    end

    // Output registers take the value for the state being entered, so pins
    // line up with the registered state and commands last one cycle.
    always_comb begin
        w_cmd = CMD_NOP;
        w_a   = '0;
        if (w_enter) begin
            case (w_state_nxt)
                ST_PRE: begin
                    w_cmd = CMD_PRE;
                    w_a   = A_ALL_BANKS;
                end
                ST_AREF: w_cmd = CMD_AREF;
                ST_LMR: begin
                    w_cmd = CMD_LMR;
                    w_a   = r_mode;
                end
                default: w_cmd = CMD_NOP;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_aref_cnt <= '0;
            r_mode     <= MR_DEFAULT;
            r_cke      <= 1'b0;
            r_cmd      <= CMD_NOP;
            r_a        <= '0;
            r_dqm      <= '1;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_ack      <= 1'b0;
        end else begin
            if (w_aref_clr) begin
                r_aref_cnt <= '0;
            end else if (w_aref_inc) begin
                r_aref_cnt <= r_aref_cnt + 4'd1;
            end
            if (w_accept) begin
                r_mode <= mr_ovr_en ? mr_cfg : MR_DEFAULT;
            end
            r_cke  <= (w_state_nxt != ST_IDLE);
            r_cmd  <= w_cmd;
            r_a    <= w_a;
            r_dqm  <= (w_state_nxt == ST_DONE) ? '0 : '1;
            r_busy <= (w_state_nxt inside {ST_PWR, ST_PRE, ST_AREF, ST_LMR});
            r_done <= (w_state_nxt == ST_DONE);
            r_ack  <= w_accept;
        end
    end

    assign reinit_ack = r_ack;
    assign init_busy  = r_busy;
    assign init_done  = r_done;
    assign sdr_CKE    = r_cke;
    assign sdr_nCS    = 1'b0;
    assign sdr_nRAS   = r_cmd[2];
    assign sdr_nCAS   = r_cmd[1];
    assign sdr_nWE    = r_cmd[0];
    assign sdr_BA     = '0;
    assign sdr_A      = r_a;
    assign sdr_DQM    = r_dqm;

endmodule

// File: tb/tb_sdr_init_seq.sv
// tb/tb_sdr_init_seq.sv - randomized self-checking bench for sdr_init_seq
module tb_sdr_init_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        reinit_req;
    logic        mr_ovr_en;
    logic [12:0] mr_cfg;

    logic [2:0]  w_ack, w_busy, w_done, w_cke, w_ncs, w_nras, w_ncas, w_nwe;
    logic [1:0]  w_ba  [3];
    logic [12:0] w_a   [3];
    logic [1:0]  w_dqm [3];

    // Instance 0: baseline timing, 1: eight refreshes, 2: single-cycle states.
    localparam int P_PWR [3] = '{20, 20, 4};
    localparam int P_RP  [3] = '{3, 3, 1};
    localparam int P_RFC [3] = '{5, 5, 1};
    localparam int P_MRD [3] = '{2, 2, 1};
    localparam int P_N   [3] = '{2, 8, 3};

    sdr_init_seq #(.T_PWR_CYC(20), .T_RP_CYC(3), .T_RFC_CYC(5), .T_MRD_CYC(2), .N_AREF(2)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .reinit_req(reinit_req), .mr_ovr_en(mr_ovr_en), .mr_cfg(mr_cfg),
        .reinit_ack(w_ack[0]), .init_busy(w_busy[0]), .init_done(w_done[0]), .sdr_CKE(w_cke[0]),
        .sdr_nCS(w_ncs[0]), .sdr_nRAS(w_nras[0]), .sdr_nCAS(w_ncas[0]), .sdr_nWE(w_nwe[0]),
        .sdr_BA(w_ba[0]), .sdr_A(w_a[0]), .sdr_DQM(w_dqm[0]));

    sdr_init_seq #(.T_PWR_CYC(20), .T_RP_CYC(3), .T_RFC_CYC(5), .T_MRD_CYC(2), .N_AREF(8)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .reinit_req(reinit_req), .mr_ovr_en(mr_ovr_en), .mr_cfg(mr_cfg),
        .reinit_ack(w_ack[1]), .init_busy(w_busy[1]), .init_done(w_done[1]), .sdr_CKE(w_cke[1]),
        .sdr_nCS(w_ncs[1]), .sdr_nRAS(w_nras[1]), .sdr_nCAS(w_ncas[1]), .sdr_nWE(w_nwe[1]),
        .sdr_BA(w_ba[1]), .sdr_A(w_a[1]), .sdr_DQM(w_dqm[1]));

    sdr_init_seq #(.T_PWR_CYC(4), .T_RP_CYC(1), .T_RFC_CYC(1), .T_MRD_CYC(1), .N_AREF(3)) u_dut_c (
        .clk(clk), .rst_n(rst_n), .reinit_req(reinit_req), .mr_ovr_en(mr_ovr_en), .mr_cfg(mr_cfg),
        .reinit_ack(w_ack[2]), .init_busy(w_busy[2]), .init_done(w_done[2]), .sdr_CKE(w_cke[2]),
        .sdr_nCS(w_ncs[2]), .sdr_nRAS(w_nras[2]), .sdr_nCAS(w_ncas[2]), .sdr_nWE(w_nwe[2]),
        .sdr_BA(w_ba[2]), .sdr_A(w_a[2]), .sdr_DQM(w_dqm[2]));

    localparam logic [12:0] MR_DEF = 13'h032;
    localparam logic [2:0]  C_NOP  = 3'b111;
    localparam logic [2:0]  C_PRE  = 3'b010;
    localparam logic [2:0]  C_AREF = 3'b001;
    localparam logic [2:0]  C_LMR  = 3'b000;

    int          cyc;
    int          n_cmp;
    int          n_err;
    int          seq_start [3];
    bit          seq_pwr   [3];
    logic [12:0] mode      [3];
    int          ack_cyc   [3];
    bit          done_prev [3];

    task automatic check_eq(input string tag, input logic [24:0] got, input logic [24:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d got=%h expected=%h", tag, cyc, got, exp);
        end
    endtask

    // {CKE, nCS, cmd[2:0], BA[1:0], A[12:0], DQM[1:0], busy, done, ack}
    function automatic logic [24:0] pack(input bit cke, input logic [2:0] cmd, input logic [12:0] a,
                                         input logic [1:0] dqm, input bit busy, input bit done);
        return {cke, 1'b0, cmd, 2'b00, a, dqm, busy, done, 1'b0};
    endfunction

    // Expected pins o cycles into a sequence, from the phase durations alone.
    function automatic logic [24:0] expect_at(input int k, input int o_in, input bit pwr, input logic [12:0] m);
        int o;
        o = o_in;
        if (pwr) begin
            if (o < P_PWR[k]) return pack(1'b1, C_NOP, 13'h0, 2'b11, 1'b1, 1'b0);
            o -= P_PWR[k];
        end
        if (o < P_RP[k])
            return pack(1'b1, (o == 0) ? C_PRE : C_NOP, (o == 0) ? 13'h400 : 13'h0, 2'b11, 1'b1, 1'b0);
        o -= P_RP[k];
        if (o < P_N[k] * P_RFC[k])
            return pack(1'b1, ((o % P_RFC[k]) == 0) ? C_AREF : C_NOP, 13'h0, 2'b11, 1'b1, 1'b0);
        o -= P_N[k] * P_RFC[k];
        if (o < P_MRD[k])
            return pack(1'b1, (o == 0) ? C_LMR : C_NOP, (o == 0) ? m : 13'h0, 2'b11, 1'b1, 1'b0);
        return pack(1'b1, C_NOP, 13'h0, 2'b00, 1'b0, 1'b1);
    endfunction

    initial begin
        logic [24:0] exp_v;
        logic [24:0] got_v;
        rst_n      = 1'b0;
        reinit_req = 1'b0;
        mr_ovr_en  = 1'b0;
        mr_cfg     = 13'h0;
        cyc        = 0;
        n_cmp      = 0;
        n_err      = 0;
        for (int k = 0; k < 3; k++) begin
            seq_start[k] = 1 << 30;
            seq_pwr[k]   = 1'b1;
            mode[k]      = MR_DEF;
            ack_cyc[k]   = -1;
            done_prev[k] = 1'b0;
        end

        for (int i = 0; i < 6000; i++) begin
            @(posedge clk);
            cyc++;
            for (int k = 0; k < 3; k++) begin
                if (!rst_n) begin
                    // Reset cycle plus one IDLE cycle, then the full sequence.
                    seq_start[k] = cyc + 2;
                    seq_pwr[k]   = 1'b1;
                    mode[k]      = MR_DEF;
                    ack_cyc[k]   = -1;
                end else if (done_prev[k] && reinit_req) begin
                    seq_start[k] = cyc;
                    seq_pwr[k]   = 1'b0;
                    mode[k]      = mr_ovr_en ? mr_cfg : MR_DEF;
                    ack_cyc[k]   = cyc;
                end
            end

            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                if (cyc < seq_start[k])
                    exp_v = pack(1'b0, C_NOP, 13'h0, 2'b11, 1'b0, 1'b0);
                else
                    exp_v = expect_at(k, cyc - seq_start[k], seq_pwr[k], mode[k]);
                if (cyc == ack_cyc[k]) exp_v[0] = 1'b1;
                done_prev[k] = exp_v[1];
                got_v = {w_cke[k], w_ncs[k], w_nras[k], w_ncas[k], w_nwe[k], w_ba[k], w_a[k],
                         w_dqm[k], w_busy[k], w_done[k], w_ack[k]};
                check_eq($sformatf("pins_inst%0d", k), got_v, exp_v);
            end

            // Early: request held high through the first sequence, one reset pulse
            // inside instance 0's second refresh; later: random requests and resets.
            rst_n      = !(i < 2 || i == 33 || (i > 150 && $urandom_range(0, 299) == 0));
            reinit_req = (i < 200) ? 1'b1 : ($urandom_range(0, 3) == 0);
            mr_ovr_en  = $urandom_range(0, 1) == 1;
            mr_cfg     = 13'($urandom_range(0, 8191));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
